truth_table_sweep: RTL
======================

TRUTH_TABLE_SWEEP -- requirements
Module: truth_table_sweep

Interface
REQ-001 Parameter N_IN, default 2: number of DUT inputs driven; legal range 1..8.
REQ-002 Parameter DWELL, default 4: clock cycles each vector is held; legal range 1..255.
REQ-003 Parameter EXPECT, default 2^N_IN-bit value 4'b1000 (AND): bit i is the expected dut_z for input vector i.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-007 dut_z  in  1  DUT output under test.
REQ-008 stim  out  N_IN  registered vector driven to the DUT inputs.
REQ-009 busy  out  1  high while a sweep is in progress.
REQ-010 done  out  1  one-cycle pulse when a sweep completes.
REQ-011 pass  out  1  sticky result of the last completed sweep: 1 when zero mismatches.
REQ-012 err_count  out  N_IN+1  number of mismatching vectors in the last or current sweep; saturates at 2^N_IN.
REQ-013 fail_valid  out  1  high once at least one mismatch has been recorded in the current or last sweep.
REQ-014 first_fail  out  N_IN  vector index of the first mismatch; valid only while fail_valid=1.

Function
REQ-015 FSM states: IDLE, APPLY, CHECK, FINISH.
REQ-016 IDLE -> APPLY when start=1; on that edge: stim<=0, dwell counter<=0, err_count<=0, fail_valid<=0, busy<=1.
REQ-017 APPLY: stim held constant; dwell counter increments each cycle; when counter reaches DWELL-1, go to CHECK on the same edge.
REQ-018 CHECK (one cycle): compare dut_z with EXPECT[stim]; on mismatch err_count+=1 and, if fail_valid=0, first_fail<=stim and fail_valid<=1.
REQ-019 CHECK -> APPLY with stim<=stim+1 and counter<=0 if stim != 2^N_IN-1; otherwise CHECK -> FINISH with stim unchanged.
REQ-020 FINISH (one cycle): done=1, busy=0, pass<=(err_count==0); next state IDLE.
REQ-021 Each vector is therefore driven for DWELL+1 cycles and dut_z is sampled during the final (CHECK) cycle; sweep latency start-edge to done = 2^N_IN*(DWELL+1)+1 cycles.
REQ-022 start while busy or in FINISH is ignored; no queuing.
REQ-023 stim never wraps during a sweep; the comparison index is stim, not a separate counter.
REQ-024 err_count, first_fail, fail_valid and pass hold their values in IDLE until the next accepted start.
REQ-025 X/Z on dut_z counts as a mismatch.

Reset
REQ-026 On rst=1 at a clock edge, regardless of state, including mid-sweep: state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0.
REQ-027 rst has priority over start on the same edge; no partial result is reported after reset.

Structure
REQ-028 Shared package tts_pkg holds the FSM state encoding (2-bit localparams) and the default EXPECT constants for AND/OR/XOR/NAND of width 2.
REQ-029 One sub-module, dwell_counter (parametrised width, load/enable/terminal-count), implements the APPLY timer; all other logic resides in truth_table_sweep.

Verification
REQ-030 N_IN=2, DWELL=4, EXPECT=4'b1000, DUT=AND, start at cycle 10 -> stim sequence 0,1,2,3 each held 5 cycles; done at cycle 31; pass=1, err_count=0, fail_valid=0.
REQ-031 Same config, DUT=OR -> done pulse; pass=0, err_count=2, fail_valid=1, first_fail=1.
REQ-032 Same config, DUT=AND, rst asserted during vector 2 -> next edge all outputs at reset values; no done pulse; a new start runs a full 21-cycle sweep to pass=1.
REQ-033 start pulsed again while busy and in FINISH cycle -> ignored; exactly one done per accepted start.
REQ-034 N_IN=3, DWELL=1, EXPECT=8'h96, DUT=3-input XOR -> 8 vectors of 2 cycles each, done 17 cycles after start, pass=1.
REQ-035 DUT output tied to X -> err_count=2^N_IN, first_fail=0, pass=0.

Source files
------------

// File: rtl/truth_table_sweep_pkg.sv
// tts_pkg: FSM state encoding and default EXPECT tables for 2-input gates.
package tts_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_APPLY  = 2'd1;
  localparam state_t ST_CHECK  = 2'd2;
  localparam state_t ST_FINISH = 2'd3;
  localparam logic [3:0] EXP_AND  = 4'b1000;
  localparam logic [3:0] EXP_OR   = 4'b1110;
  localparam logic [3:0] EXP_XOR  = 4'b0110;
  localparam logic [3:0] EXP_NAND = 4'b0111;
endpackage

// File: rtl/truth_table_sweep_dwell_counter.sv
// dwell_counter: loadable up-counter with a terminal-count flag.
module dwell_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? '0 : en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc = cnt_q == term;
endmodule

// File: rtl/truth_table_sweep.sv
// truth_table_sweep: drives every input vector to a DUT and checks its output against a truth table.
module truth_table_sweep import tts_pkg::*; #(
  parameter int                  N_IN   = 2,
  parameter int                  DWELL  = 4,
  parameter logic [2**N_IN-1:0]  EXPECT = EXP_AND
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            dut_z,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_valid,
  output logic [N_IN-1:0] first_fail
);
  localparam logic [N_IN:0] NV = (N_IN+1)'(2**N_IN);
  state_t state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d, ff_q, ff_d;
  logic [N_IN:0] err_q, err_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fv_q, fv_d;
  logic exp_bit, mis, last, tc, cnt_load;
  dwell_counter #(.W(8)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (state_q == ST_APPLY),
    .term (8'(DWELL - 1)),
    .tc   (tc)
  );
  always_comb begin
    exp_bit = EXPECT[stim_q];
    // Case equality so an X or Z response is never mistaken for a match.
    mis = (dut_z === exp_bit) ? 1'b0 : 1'b1;
    last = &stim_q;
    cnt_load = (state_q == ST_IDLE && start) || (state_q == ST_CHECK && !last);
    state_d = state_q;
    stim_d = stim_q;
    ff_d = ff_q;
    err_d = err_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    fv_d = fv_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_APPLY;
        stim_d = '0;
        err_d = '0;
        fv_d = 1'b0;
        busy_d = 1'b1;
      end
      ST_APPLY: state_d = tc ? ST_CHECK : ST_APPLY;
      ST_CHECK: begin
        if (mis) begin
          err_d = (err_q == NV) ? err_q : err_q + (N_IN+1)'(1);
          ff_d = fv_q ? ff_q : stim_q;
          fv_d = 1'b1;
        end
        state_d = last ? ST_FINISH : ST_APPLY;
        stim_d = last ? stim_q : stim_q + N_IN'(1);
        busy_d = !last;
        done_d = last;
      end
      default: begin
        pass_d = err_q == '0;
        state_d = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stim_q <= '0;
      ff_q <= '0;
      err_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q <= stim_d;
      ff_q <= ff_d;
      err_q <= err_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fv_q <= fv_d;
    end
  end
  assign stim = stim_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign err_count = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;
endmodule
